// File: rtl/divider_unit.sv
`default_nettype none
// ============================================================================
// Module      : divider_unit
// Description : Iterative 32-bit integer divider with RISC-V DIV/DIVU/REM/REMU
//               semantics. A one-cycle start pulse launches a restoring
//               shift-subtract division (one quotient bit per cycle, MSB
//               first). ready is high when the block is idle and q/r/flags
//               hold the result of the last operation.
//
// Ports       : clk         - rising-edge clock
//               nrst        - synchronous reset, ACTIVE-HIGH despite its name
//               en          - start pulse, accepted only while idle
//               is_signed   - 1: two's-complement operands, 0: unsigned
//               a, b        - dividend / divisor, sampled with en
//               q, r        - quotient / remainder
//               ready       - idle, results valid
//               div_by_zero - last operation had b == 0
//               overflow    - last operation was signed INT_MIN / -1
//
// Revision    : 1.0 - initial release
// ============================================================================
module divider_unit (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        ready,
    output logic        div_by_zero,
    output logic        overflow
);

    localparam logic [31:0] c_INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] c_ALL_ONES  = 32'hFFFF_FFFF;
    localparam logic [4:0]  c_LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Operand capture
    logic [31:0] r_a_raw;       // raw dividend, returned as r on divide-by-zero
    logic [31:0] r_b_raw;
    logic        r_signed;
    logic        r_neg_q;       // operand signs differ (signed mode)
    logic        r_neg_r;       // dividend negative (signed mode)

    // Iteration state: r_dvd starts as the dividend magnitude and fills up
    // with quotient bits from the right as dividend bits shift out the left.
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [31:0] r_rem;
    logic [4:0]  r_count;

    // Result registers
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic        r_dbz;
    logic        r_ovf;

    // Control strobes from the FSM
    logic        w_accept;
    logic        w_do_dbz;
    logic        w_do_ovf;
    logic        w_iter;
    logic        w_fix;

    // Datapath wires
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_b_zero;
    logic        w_ovf_case;
    logic [32:0] w_shifted;
    logic [31:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_next;

    assign w_a_mag = (is_signed && a[31]) ? (~a + 32'd1) : a;
    assign w_b_mag = (is_signed && b[31]) ? (~b + 32'd1) : b;

    assign w_b_zero   = (r_b_raw == 32'd0);
    assign w_ovf_case = r_signed && (r_a_raw == c_INT_MIN) && (r_b_raw == c_ALL_ONES);

    // 33-bit partial remainder: previous remainder shifted left with the next
    // dividend bit appended. When the subtraction succeeds the true difference
    // is below the divisor, so its low 32 bits are exact.
    assign w_shifted  = {r_rem, r_dvd[31]};
    assign w_qbit     = (w_shifted >= {1'b0, r_dvs});
    assign w_diff     = w_shifted[31:0] - r_dvs;
    assign w_rem_next = w_qbit ? w_diff : w_shifted[31:0];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_do_dbz     = 1'b0;
        w_do_ovf     = 1'b0;
        w_iter       = 1'b0;
        w_fix        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // Special cases can only be seen on the first BUSY edge,
                // because they send the block straight back to IDLE.
                if (w_b_zero) begin
                    w_do_dbz     = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_ovf_case) begin
                    w_do_ovf     = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_iter = 1'b1;
                    if (r_count == c_LAST_ITER) begin
                        w_state_next = S_FIX;
                    end
                end
            end
            S_FIX: begin
                w_fix        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_a_raw  <= 32'd0;
            r_b_raw  <= 32'd0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dvd    <= 32'd0;
            r_dvs    <= 32'd0;
            r_rem    <= 32'd0;
            r_count  <= 5'd0;
            r_q      <= 32'd0;
            r_r      <= 32'd0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_raw  <= a;
                r_b_raw  <= b;
                r_signed <= is_signed;
                r_neg_q  <= is_signed && (a[31] ^ b[31]);
                r_neg_r  <= is_signed && a[31];
                r_dvd    <= w_a_mag;
                r_dvs    <= w_b_mag;
                r_rem    <= 32'd0;
                r_count  <= 5'd0;
                r_dbz    <= 1'b0;
                r_ovf    <= 1'b0;
            end

            if (w_do_dbz) begin
                r_q   <= c_ALL_ONES;
                r_r   <= r_a_raw;
                r_dbz <= 1'b1;
            end

            if (w_do_ovf) begin
                r_q   <= c_INT_MIN;
                r_r   <= 32'd0;
                r_ovf <= 1'b1;
            end

            if (w_iter) begin
                r_rem   <= w_rem_next;
                r_dvd   <= {r_dvd[30:0], w_qbit};
                r_count <= r_count + 5'd1;
            end

            if (w_fix) begin
                r_q <= r_neg_q ? (~r_dvd + 32'd1) : r_dvd;
                r_r <= r_neg_r ? (~r_rem + 32'd1) : r_rem;
            end
        end
    end

    assign q           = r_q;
    assign r           = r_r;
    assign ready       = (r_state == S_IDLE);
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_divider_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_unit
// Description : Self-checking bench for divider_unit. Expected results come
//               from a behavioural reference model, are queued when an
//               operation is launched and are popped when ready returns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_unit;

    logic        clk;
    logic        nrst;
    logic        en;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        ready;
    logic        div_by_zero;
    logic        overflow;

    divider_unit dut (
        .clk         (clk),
        .nrst        (nrst),
        .en          (en),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .q           (q),
        .r           (r),
        .ready       (ready),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t_acc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: truncating division, remainder takes the dividend's sign.
    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_v,
                                   input logic ts);
        exp_t e;
        logic signed [31:0] sa;
        logic signed [31:0] sb_v;
        sa   = ta;
        sb_v = tb_v;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.lat = 33;
        if (tb_v == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = ta; e.dbz = 1'b1; e.lat = 1;
        end else if (ts && ta == 32'h8000_0000 && tb_v == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.ovf = 1'b1; e.lat = 1;
        end else if (ts) begin
            e.q = sa / sb_v;
            e.r = sa % sb_v;
        end else begin
            e.q = ta / tb_v;
            e.r = ta % tb_v;
        end
        return e;
    endfunction

    task automatic launch(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        chk("ready_before_start", {31'd0, ready}, 32'd1);
        a = ta; b = tb_v; is_signed = ts; en = 1'b1;
        sb.push_back(model(ta, tb_v, ts));
        @(posedge clk); #1;
        t_acc = cyc;
        en = 1'b0; a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
        chk("ready_fall", {31'd0, ready}, 32'd0);
        chk("dbz_busy", {31'd0, div_by_zero}, 32'd0);
        chk("ovf_busy", {31'd0, overflow}, 32'd0);
    endtask

    task automatic finish_op(input string tag);
        int guard;
        exp_t e;
        guard = 0;
        while (ready !== 1'b1 && guard < 60) begin
            @(posedge clk); #1; guard++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, cyc - t_acc, e.lat);
            chk({tag, "_q"}, q, e.q);
            chk({tag, "_r"}, r, e.r);
            chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
            chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
            last_e = e;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts);
        launch(ta, tb_v, ts);
        finish_op(tag);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        nrst = 1'b1; en = 1'b0; is_signed = 1'b0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        // Reset must override a concurrent start request
        en = 1'b1; a = 32'd55; b = 32'd5;
        @(posedge clk); #1;
        en = 1'b0;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_q", q, 32'd0);
        chk("rst_r", r, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        nrst = 1'b0;
        @(posedge clk); #1;
        chk("rst_still_idle", {31'd0, ready}, 32'd1);

        // Directed cases
        run_op("u_div0", 32'd10, 32'd0, 1'b0);
        run_op("u_ident", 32'h8210_AB90, 32'd1, 1'b0);
        run_op("u_ones", 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op("s_m1_1", 32'hFFFF_FFFF, 32'd1, 1'b1);
        run_op("s_div0", 32'd10, 32'd0, 1'b1);
        run_op("u_big", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
        run_op("s_min_2", 32'h8000_0000, 32'd2, 1'b1);

        // Outputs hold while idle, even with inputs wiggling
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            chk("hold_q", q, last_e.q);
            chk("hold_r", r, last_e.r);
            chk("hold_ready", {31'd0, ready}, 32'd1);
        end

        // Second start pulse while busy is ignored
        launch(32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        en = 1'b1; a = 32'd5; b = 32'd1; is_signed = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        finish_op("busy_en_ignored");

        // Reset in the middle of an iteration run
        launch(32'd1000, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        nrst = 1'b0;
        void'(sb.pop_back());
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_q", q, 32'd0);
        chk("midrst_r", r, 32'd0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow}, 32'd0);
        run_op("after_rst", 32'd1000, 32'd3, 1'b0);

        // Random operands; each launch happens in the first ready cycle
        for (int i = 0; i < 1001; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op("rand_u", ra, rb, 1'b0);
        end
        for (int i = 0; i < 1001; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
            run_op("rand_s", ra, rb, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
